lock_key_verifier: RTL and testbench
====================================

Name: lock_key_verifier

Overview:
- Sequencer that checks a candidate key against a key-gate-locked combinational circuit.
- Holds the key stable and sweeps every input pattern. For each pattern it queries an external oracle (the unlocked reference), compares the oracle response with the locked circuit's outputs, and counts mismatches.
- Sits between the key-search logic and the locked netlist/oracle pair. It is used to confirm a recovered key after a SAT attack.

Parameters:
- N_IN, 7, locked-circuit primary input width; the sweep covers 2^N_IN patterns.
- N_KEY, 4, key width.
- N_OUT, 3, locked-circuit output width.
- TIMEOUT, 15, maximum cycles to wait for orc_ack per query.
- STOP_ON_FAIL, 0, 1 = end the sweep at the first mismatch.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a sweep; sampled only in IDLE
- key_in  in  N_KEY  candidate key; bit0 = key1
- key_out  out  N_KEY  key driven to the locked circuit's key gates
- pat_out  out  N_IN  pattern driven to the locked circuit and the oracle; bit0 = I1
- locked_o  in  N_OUT  locked-circuit outputs; bit0 = O1
- orc_req  out  1  oracle request for pat_out
- orc_ack  in  1  oracle response valid
- orc_o  in  N_OUT  oracle outputs
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse when the sweep ends
- pass  out  1  last sweep had zero mismatches and no timeout
- timeout_err  out  1  last sweep aborted on an oracle timeout
- mismatch_count  out  N_IN+1  mismatching patterns in the last sweep
- first_fail  out  N_IN  lowest mismatching pattern; valid when fail_valid
- fail_valid  out  1  at least one mismatch seen

Behaviour:
- Reset values: every output is 0, the FSM is in IDLE, and internal counters are 0. Reset takes effect in any state, including mid-sweep; no done pulse is issued.
- IDLE: busy=0. On start=1, latch key_in into key_out, clear pat, mismatch_count, first_fail, fail_valid, pass and timeout_err, then go to APPLY.
- APPLY: busy=1. pat_out = current pattern. One settle cycle for the combinational locked circuit, then go to QUERY.
- QUERY: orc_req=1 and pat_out held.
  - If orc_ack=1 in a cycle, register orc_o and locked_o together in that cycle (zero-latency ack is allowed) and go to COMPARE.
  - The wait counter increments on every cycle without ack. When it reaches TIMEOUT, set timeout_err=1 and go to FINISH.
- COMPARE: orc_req=0. A mismatch occurs when the captured oracle and locked vectors differ in any bit.
  - On mismatch: mismatch_count += 1. If fail_valid=0, set first_fail = pat and fail_valid = 1.
  - If a mismatch occurred and STOP_ON_FAIL=1, go to FINISH.
  - Otherwise, if pat = 2^N_IN-1, go to FINISH.
  - Otherwise increment pat and go to APPLY.
- FINISH: done=1 for exactly one cycle. pass = (mismatch_count==0) and not timeout_err. Go to IDLE, with busy=0 from the next cycle.
- Result registers (pass, mismatch_count, first_fail, fail_valid, timeout_err) hold their values until the next accepted start.
- mismatch_count is N_IN+1 bits wide so that a full count of 2^N_IN does not wrap. The pattern counter never wraps; the terminal check happens before the increment.
- start is ignored while busy. key_in changes during a sweep have no effect.
- orc_ack outside QUERY is ignored.
- Latency with a zero-latency oracle: 3 cycles per pattern. A full 128-pattern sweep runs 384 cycles from start acceptance to the FINISH cycle.

Test Plan:
- Oracle model = unlocked sample circuit (ack tied high); key_in=4'b0000 (correct key) -> done after 385 cycles; pass=1, mismatch_count=0, fail_valid=0.
- key_in=4'b0001 (key1 inverted) -> O3 differs whenever I3=1: mismatch_count=64, first_fail=7'd4, pass=0.
- key_in=4'b0100 (key3 inverted) -> O2 always inverted: mismatch_count=128, first_fail=0. Repeat with STOP_ON_FAIL=1: mismatch_count=1, done at cycle 4.
- key_in=4'b1000 (key4 inverted), oracle acks after 3 cycles -> mismatch_count=64, first_fail=7'd8, 6 cycles per pattern.
- Oracle never acks for pattern 5 -> timeout_err=1, pass=0, done pulses 15 cycles after QUERY entry for pat 5; busy drops the next cycle.
- Assert rst at pattern 40 of a sweep -> all outputs 0 the next cycle with no done pulse. start while busy is ignored; a new start after reset runs a clean sweep.

Source files
------------

// File: rtl/lock_key_verifier.sv
// Sweeps every input pattern of a key-locked circuit with the key held fixed and counts oracle mismatches.
// 3 cycles per pattern with a zero-latency oracle; orc_req is held until orc_ack or a TIMEOUT abort.
module lock_key_verifier #(
  parameter int N_IN         = 7,
  parameter int N_KEY        = 4,
  parameter int N_OUT        = 3,
  parameter int TIMEOUT      = 15,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_KEY-1:0] key_in,
  output logic [N_KEY-1:0] key_out,
  output logic [N_IN-1:0]  pat_out,
  input  logic [N_OUT-1:0] locked_o,
  output logic             orc_req,
  input  logic             orc_ack,
  input  logic [N_OUT-1:0] orc_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout_err,
  output logic [N_IN:0]    mismatch_count,
  output logic [N_IN-1:0]  first_fail,
  output logic             fail_valid
);

  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    QUERY,
    COMPARE,
    FINISH
  } state_t;

  state_t            state;
  logic [WW-1:0]     wait_cnt;
  logic [WW-1:0]     wait_nxt;
  logic [N_OUT-1:0]  cap_orc;
  logic [N_OUT-1:0]  cap_lock;
  logic              mism;
  logic              last_pat;
  logic              stop_hit;
  logic [N_IN:0]     cnt_nxt;

  always_comb begin
    mism     = |(cap_orc ^ cap_lock);
    cnt_nxt  = mismatch_count + {{N_IN{1'b0}}, mism};
    wait_nxt = wait_cnt + 1'b1;
    last_pat = (pat_out == {N_IN{1'b1}});
    stop_hit = mism && (STOP_ON_FAIL != 0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      cap_orc        <= '0;
      cap_lock       <= '0;
      key_out        <= '0;
      pat_out        <= '0;
      orc_req        <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout_err    <= 1'b0;
      mismatch_count <= '0;
      first_fail     <= '0;
      fail_valid     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            key_out        <= key_in;
            pat_out        <= '0;
            mismatch_count <= '0;
            first_fail     <= '0;
            fail_valid     <= 1'b0;
            pass           <= 1'b0;
            timeout_err    <= 1'b0;
            busy           <= 1'b1;
            state          <= APPLY;
          end
        end
        APPLY: begin
          // locked circuit settles on pat_out during this cycle
          wait_cnt <= '0;
          orc_req  <= 1'b1;
          state    <= QUERY;
        end
        QUERY: begin
          if (orc_ack) begin
            cap_orc  <= orc_o;
            cap_lock <= locked_o;
            orc_req  <= 1'b0;
            state    <= COMPARE;
          end else if (wait_nxt == WW'(TIMEOUT)) begin
            timeout_err <= 1'b1;
            pass        <= 1'b0;
            orc_req     <= 1'b0;
            done        <= 1'b1;
            state       <= FINISH;
          end else begin
            wait_cnt <= wait_nxt;
          end
        end
        COMPARE: begin
          mismatch_count <= cnt_nxt;
          if (mism && !fail_valid) begin
            first_fail <= pat_out;
            fail_valid <= 1'b1;
          end
          // terminal check precedes the increment so pat_out never wraps
          if (stop_hit || last_pat) begin
            pass  <= (cnt_nxt == '0);
            done  <= 1'b1;
            state <= FINISH;
          end else begin
            pat_out <= pat_out + 1'b1;
            state   <= APPLY;
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lock_key_verifier.sv
// Drives two verifiers (run-to-end and stop-on-first-fail) against a sample locked circuit and its oracle.
module tb_lock_key_verifier;

  localparam int N_IN = 7, N_KEY = 4, N_OUT = 3, TIMEOUT = 15, NPAT = 1 << N_IN;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             start_stim = 1'b0, start_noise = 1'b0, start;
  logic [N_KEY-1:0] key_stim = '0, key_noise = '0, key_in;
  logic             scr_active = 1'b0, noise_bit = 1'b0;
  int               ack_delay = 0, noack_pat = -1;
  bit               noise_en = 0, scramble_en = 0;

  assign start  = start_stim | start_noise;
  assign key_in = scr_active ? key_noise : key_stim;

  int n_cmp = 0, n_err = 0;

  // Sample locked circuit; the all-zero key unlocks it, so the oracle is key 0.
  function automatic logic [2:0] circ(logic [6:0] i, logic [3:0] k);
    logic o1, o2, o3;
    o1 = ((i[0] & i[1]) | i[4]) ^ (k[1] & i[5]);
    o2 = (i[1] ^ i[5]) ^ k[2];
    o3 = (i[0] | i[6]) ^ (i[2] & k[0]) ^ (i[3] & k[3]);
    return {o3, o2, o1};
  endfunction

  // DUT A: STOP_ON_FAIL = 0
  logic [N_KEY-1:0] key_out_a;
  logic [N_IN-1:0]  pat_out_a, ff_a;
  logic [N_OUT-1:0] locked_a, orc_a;
  logic             req_a, ack_a, busy_a, done_a, pass_a, to_a, fv_a;
  logic [N_IN:0]    mc_a;
  int               req_cnt_a = 0;

  // DUT S: STOP_ON_FAIL = 1
  logic [N_KEY-1:0] key_out_s;
  logic [N_IN-1:0]  pat_out_s, ff_s;
  logic [N_OUT-1:0] locked_s, orc_s;
  logic             req_s, ack_s, busy_s, done_s, pass_s, to_s, fv_s;
  logic [N_IN:0]    mc_s;
  int               req_cnt_s = 0;

  assign locked_a = circ(pat_out_a, key_out_a);
  assign orc_a    = circ(pat_out_a, 4'b0000);
  assign ack_a    = req_a ? (req_cnt_a >= ack_delay && int'(pat_out_a) != noack_pat)
                          : (noise_en && noise_bit);
  assign locked_s = circ(pat_out_s, key_out_s);
  assign orc_s    = circ(pat_out_s, 4'b0000);
  assign ack_s    = req_s ? (req_cnt_s >= ack_delay && int'(pat_out_s) != noack_pat)
                          : (noise_en && noise_bit);

  always @(posedge clk) begin
    req_cnt_a <= req_a ? req_cnt_a + 1 : 0;
    req_cnt_s <= req_s ? req_cnt_s + 1 : 0;
  end

  lock_key_verifier #(.N_IN(N_IN), .N_KEY(N_KEY), .N_OUT(N_OUT), .TIMEOUT(TIMEOUT), .STOP_ON_FAIL(0)) u_dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .key_out(key_out_a), .pat_out(pat_out_a),
    .locked_o(locked_a), .orc_req(req_a), .orc_ack(ack_a), .orc_o(orc_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .timeout_err(to_a), .mismatch_count(mc_a), .first_fail(ff_a), .fail_valid(fv_a));

  lock_key_verifier #(.N_IN(N_IN), .N_KEY(N_KEY), .N_OUT(N_OUT), .TIMEOUT(TIMEOUT), .STOP_ON_FAIL(1)) u_stop (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .key_out(key_out_s), .pat_out(pat_out_s),
    .locked_o(locked_s), .orc_req(req_s), .orc_ack(ack_s), .orc_o(orc_s), .busy(busy_s), .done(done_s),
    .pass(pass_s), .timeout_err(to_s), .mismatch_count(mc_s), .first_fail(ff_s), .fail_valid(fv_s));

  typedef struct {
    int cnt;
    int first;
    bit fv;
    bit pass;
    bit to;
    int cycles;
  } exp_t;

  exp_t q_a[$], q_s[$];
  exp_t ea, es;

  // Reference: walk patterns in order, charging delay+3 cycles per answered query.
  function automatic exp_t model(logic [3:0] key, int delay, int noack, bit stop);
    exp_t e;
    e = '{default: 0};
    for (int p = 0; p < NPAT; p++) begin
      if (p == noack || delay >= TIMEOUT) begin
        e.to = 1;
        e.cycles += 1 + TIMEOUT;
        break;
      end
      e.cycles += delay + 3;
      if (circ(7'(p), key) != circ(7'(p), 4'b0000)) begin
        if (!e.fv) begin
          e.first = p;
          e.fv    = 1;
        end
        e.cnt++;
        if (stop) break;
      end
    end
    e.cycles += 1;
    e.pass = (e.cnt == 0) && !e.to;
    return e;
  endfunction

  task automatic chk(string nm, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_res(string tag, exp_t e, int mc, int ff, bit fv, bit ps, bit to, int cyc);
    chk({tag, "_mismatch_count"}, mc, e.cnt);
    chk({tag, "_first_fail"}, ff, e.first);
    chk({tag, "_fail_valid"}, fv, e.fv);
    chk({tag, "_pass"}, ps, e.pass);
    chk({tag, "_timeout_err"}, to, e.to);
    chk({tag, "_busy_cycles"}, cyc, e.cycles);
  endtask

  always @(negedge clk) begin
    noise_bit   = 1'($urandom_range(0, 1));
    key_noise   = 4'($urandom);
    scr_active  = scramble_en && busy_a && busy_s;
    start_noise = scr_active && ($urandom_range(0, 7) == 0);
  end

  int  cyc_a = 0, cyc_s = 0;
  bit  after_a = 0, after_s = 0;

  always @(negedge clk) begin
    if (rst) begin
      cyc_a = 0;
      after_a = 0;
    end else begin
      if (after_a) begin
        chk("a_busy_after_done", busy_a, 0);
        after_a = 0;
      end
      if (busy_a) cyc_a++;
      if (done_a) begin
        if (q_a.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL a_unexpected_done: got done=1, expected no sweep outstanding");
        end else begin
          ea = q_a.pop_front();
          check_res("a", ea, int'(mc_a), int'(ff_a), fv_a, pass_a, to_a, cyc_a);
        end
        cyc_a = 0;
        after_a = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      cyc_s = 0;
      after_s = 0;
    end else begin
      if (after_s) begin
        chk("s_busy_after_done", busy_s, 0);
        after_s = 0;
      end
      if (busy_s) cyc_s++;
      if (done_s) begin
        if (q_s.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL s_unexpected_done: got done=1, expected no sweep outstanding");
        end else begin
          es = q_s.pop_front();
          check_res("s", es, int'(mc_s), int'(ff_s), fv_s, pass_s, to_s, cyc_s);
        end
        cyc_s = 0;
        after_s = 1;
      end
    end
  end

  task automatic wait_quiet(int budget);
    int n = 0;
    while ((busy_a || busy_s || q_a.size() != 0 || q_s.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      n_cmp++;
      n_err++;
      $display("FAIL sweep_bound: still busy after %0d cycles, expected done and idle", budget);
      rst = 1'b1;
      q_a.delete();
      q_s.delete();
      @(negedge clk);
      rst = 1'b0;
    end
  endtask

  task automatic launch(logic [3:0] key, int delay, int noack, bit noise, bit scr);
    @(negedge clk);
    ack_delay   = delay;
    noack_pat   = noack;
    noise_en    = noise;
    scramble_en = scr;
    key_stim    = key;
    q_a.push_back(model(key, delay, noack, 0));
    q_s.push_back(model(key, delay, noack, 1));
    start_stim = 1'b1;
    @(negedge clk);
    start_stim = 1'b0;
    key_stim   = 4'($urandom);
  endtask

  task automatic run(logic [3:0] key, int delay, int noack, bit noise, bit scr);
    launch(key, delay, noack, noise, scr);
    wait_quiet(3000);
  endtask

  task automatic reset_mid();
    int n = 0;
    launch(4'b0000, 0, -1, 0, 0);
    while (pat_out_a != 7'd40 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reached_pat40", pat_out_a, 40);
    rst = 1'b1;
    q_a.delete();
    q_s.delete();
    @(negedge clk);
    chk("mid_rst_a_outputs", {key_out_a, pat_out_a, req_a, busy_a, done_a, pass_a, to_a, mc_a, ff_a, fv_a}, 0);
    chk("mid_rst_s_outputs", {key_out_s, pat_out_s, req_s, busy_s, done_s, pass_s, to_s, mc_s, ff_s, fv_s}, 0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("mid_rst_no_done", {done_a, done_s, busy_a, busy_s}, 0);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_a_outputs", {key_out_a, pat_out_a, req_a, busy_a, done_a, pass_a, to_a, mc_a, ff_a, fv_a}, 0);
    chk("reset_s_outputs", {key_out_s, pat_out_s, req_s, busy_s, done_s, pass_s, to_s, mc_s, ff_s, fv_s}, 0);
    rst = 1'b0;

    run(4'b0000, 0, -1, 0, 0);  // correct key
    run(4'b0001, 0, -1, 0, 0);  // O3 flips when I3=1
    run(4'b0100, 0, -1, 0, 0);  // O2 always flipped
    run(4'b1000, 3, -1, 0, 0);  // slow oracle, O3 flips when I4=1
    run(4'b0000, 0, 5, 0, 0);   // oracle dead on pattern 5
    run(4'b0010, 14, -1, 0, 0); // ack on the last allowed wait cycle
    run(4'b0000, 15, -1, 0, 0); // ack one cycle too late
    run(4'b0100, 1, -1, 1, 1);  // stray acks, key churn, start while busy
    reset_mid();
    run(4'b0001, 0, -1, 0, 1);

    for (int i = 0; i < 6; i++) begin
      run(4'($urandom), $urandom_range(0, 3),
          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NPAT - 1)) : -1,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
